text_console_writer: RTL and testbench

Write-side companion to the video character generator: accepts a stream of character bytes, interprets a small set of control codes, and writes display codes into the character RAM that the generator scans out. It owns the cursor, line wrap, full-screen clear and hardware scroll (row copy). It drives the second (write) port of the dual-port character RAM; the generator keeps the read port.

---
 rtl/text_console_writer.sv | 208 ++++++++++++++++++++
 tb/tb_text_console_writer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_writer.sv
// Write-side console engine for the character generator: decodes a byte stream,
// tracks the cursor and drives the write port of the character RAM (clear, text, scroll).
module text_console_writer #(
    parameter int unsigned COLS = 64,
    parameter int unsigned ROWS = 30
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  DATA,
    input  logic        DATA_VALID,
    output logic        DATA_READY,
    output logic [10:0] RAM_A,
    output logic [7:0]  RAM_D,
    output logic        RAM_WE,
    input  logic [7:0]  RAM_Q,
    output logic [4:0]  CURSOR_ROW,
    output logic [5:0]  CURSOR_COL,
    output logic        BUSY
);

    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [4:0] PEN_ROW  = 5'(ROWS - 2);
    localparam logic [5:0] SCAN_END = 6'(ROWS);
    localparam logic [7:0] SPACE    = 8'h20;

    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_WRITE, S_SCROLL_RD, S_SCROLL_WR, S_SCROLL_CLR
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  row_q, row_d;
    logic [5:0]  col_q, col_d;
    logic        inv_q, inv_d;
    logic        pend_q, pend_d;
    logic [5:0]  scan_row_q, scan_row_d;
    logic [5:0]  scan_col_q, scan_col_d;
    logic [10:0] ram_a_q, ram_a_d;
    logic [7:0]  ram_d_q, ram_d_d;
    logic        ram_we_q, ram_we_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        accept;
    logic        start_scroll;

    assign accept = DATA_VALID && ready_q;

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        inv_d        = inv_q;
        pend_d       = pend_q;
        scan_row_d   = scan_row_q;
        scan_col_d   = scan_col_q;
        ram_a_d      = ram_a_q;
        ram_d_d      = SPACE;
        ram_we_d     = 1'b0;
        start_scroll = 1'b0;

        case (state_q)
            S_CLEAR: begin
                if (scan_row_q < SCAN_END) begin
                    ram_we_d = 1'b1;
                    ram_a_d  = {scan_row_q[4:0], scan_col_q};
                    if (scan_col_q == LAST_COL) begin
                        scan_col_d = 6'd0;
                        scan_row_d = scan_row_q + 6'd1;
                    end else begin
                        scan_col_d = scan_col_q + 6'd1;
                    end
                end else begin
                    state_d    = S_IDLE;
                    scan_row_d = 6'd0;
                    scan_col_d = 6'd0;
                end
            end
            S_IDLE: begin
                if (accept) begin
                    if (DATA >= 8'h20 && DATA <= 8'h7E) begin
                        state_d  = S_WRITE;
                        ram_we_d = 1'b1;
                        ram_a_d  = {row_q, col_q};
                        ram_d_d  = {inv_q, DATA[6:0]};
                        if (col_q == LAST_COL) begin
                            col_d = 6'd0;
                            if (row_q == LAST_ROW) pend_d = 1'b1;
                            else                   row_d  = row_q + 5'd1;
                        end else begin
                            col_d = col_q + 6'd1;
                        end
                    end else begin
                        case (DATA)
                            8'h0D: col_d = 6'd0;
                            8'h0A: begin
                                if (row_q == LAST_ROW) start_scroll = 1'b1;
                                else                   row_d = row_q + 5'd1;
                            end
                            8'h08: if (col_q != 6'd0) col_d = col_q - 6'd1;
                            8'h0C: begin
                                row_d      = 5'd0;
                                col_d      = 6'd0;
                                scan_row_d = 6'd0;
                                scan_col_d = 6'd0;
                                state_d    = S_CLEAR;
                            end
                            8'h0E: inv_d = 1'b1;
                            8'h0F: inv_d = 1'b0;
                            default: ;
                        endcase
                    end
                end
            end
            S_WRITE: begin
                pend_d = 1'b0;
                if (pend_q) start_scroll = 1'b1;
                else        state_d = S_IDLE;
            end
            S_SCROLL_RD: begin
                state_d  = S_SCROLL_WR;
                ram_we_d = 1'b1;
                ram_a_d  = {scan_row_q[4:0], scan_col_q};
            end
            S_SCROLL_WR: begin
                if (scan_col_q == LAST_COL) begin
                    scan_col_d = 6'd0;
                    if (scan_row_q[4:0] == PEN_ROW) begin
                        state_d  = S_SCROLL_CLR;
                        ram_we_d = 1'b1;
                        ram_a_d  = {LAST_ROW, 6'd0};
                    end else begin
                        state_d    = S_SCROLL_RD;
                        scan_row_d = scan_row_q + 6'd1;
                        ram_a_d    = {scan_row_q[4:0] + 5'd2, 6'd0};
                    end
                end else begin
                    state_d    = S_SCROLL_RD;
                    scan_col_d = scan_col_q + 6'd1;
                    ram_a_d    = {scan_row_q[4:0] + 5'd1, scan_col_q + 6'd1};
                end
            end
            S_SCROLL_CLR: begin
                if (scan_col_q == LAST_COL) begin
                    state_d    = S_IDLE;
                    scan_col_d = 6'd0;
                end else begin
                    scan_col_d = scan_col_q + 6'd1;
                    ram_we_d   = 1'b1;
                    ram_a_d    = {LAST_ROW, scan_col_q + 6'd1};
                end
            end
            default: state_d = S_CLEAR;
        endcase

        // Scroll starts by presenting the source of destination cell 0 (row 1)
        if (start_scroll) begin
            state_d    = S_SCROLL_RD;
            scan_row_d = 6'd0;
            scan_col_d = 6'd0;
            ram_a_d    = {5'd1, 6'd0};
            ram_we_d   = 1'b0;
        end

        ready_d = (state_d == S_IDLE);
        busy_d  = !ready_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_CLEAR;
            row_q      <= 5'd0;
            col_q      <= 6'd0;
            inv_q      <= 1'b0;
            pend_q     <= 1'b0;
            scan_row_q <= 6'd0;
            scan_col_q <= 6'd0;
            ram_a_q    <= 11'd0;
            ram_d_q    <= SPACE;
            ram_we_q   <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            inv_q      <= inv_d;
            pend_q     <= pend_d;
            scan_row_q <= scan_row_d;
            scan_col_q <= scan_col_d;
            ram_a_q    <= ram_a_d;
            ram_d_q    <= ram_d_d;
            ram_we_q   <= ram_we_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    // Scroll copy forwards the RAM read data straight back as write data
    assign RAM_D      = (state_q == S_SCROLL_WR) ? RAM_Q : ram_d_q;
    assign RAM_A      = ram_a_q;
    assign RAM_WE     = ram_we_q;
    assign DATA_READY = ready_q;
    assign BUSY       = busy_q;
    assign CURSOR_ROW = row_q;
    assign CURSOR_COL = col_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: character RAM model plus a screen-level console
// reference model, directed steps followed by a randomized byte stream.
module tb_text_console_writer;

    localparam int unsigned COLS = 64;
    localparam int unsigned ROWS = 30;
    localparam int NCELL = COLS * ROWS;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  DATA;
    logic        DATA_VALID;
    logic        DATA_READY;
    logic [10:0] RAM_A;
    logic [7:0]  RAM_D;
    logic        RAM_WE;
    logic [7:0]  ram_q;
    logic [4:0]  CURSOR_ROW;
    logic [5:0]  CURSOR_COL;
    logic        BUSY;

    always #5 CLK = ~CLK;

    text_console_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .CLK(CLK), .RESET(RESET), .DATA(DATA), .DATA_VALID(DATA_VALID),
        .DATA_READY(DATA_READY), .RAM_A(RAM_A), .RAM_D(RAM_D), .RAM_WE(RAM_WE),
        .RAM_Q(ram_q), .CURSOR_ROW(CURSOR_ROW), .CURSOR_COL(CURSOR_COL), .BUSY(BUSY)
    );

    // Character RAM model (write port from DUT, synchronous read)
    logic [7:0] mem [0:2047];
    logic       init_req;
    logic       preload_req;
    always @(posedge CLK) begin
        if (init_req) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 8'hFF;
        end else if (preload_req) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) mem[r*64 + c] <= 8'(r);
        end else if (RAM_WE === 1'b1) begin
            mem[RAM_A] <= RAM_D;
        end
        ram_q <= mem[RAM_A];
    end

    // Write-port monitor
    int          wr_count = 0;
    int          rst_cnt = 0;
    int          bad_addr = 0;
    int          we_idle = 0;
    logic [10:0] last_addr = '0;
    logic [10:0] first_addr = '0;
    always @(posedge CLK) begin
        if (!RESET && RAM_WE === 1'b1) begin
            wr_count  <= wr_count + 1;
            last_addr <= RAM_A;
            if (int'(RAM_A[10:6]) >= ROWS || int'(RAM_A[5:0]) >= COLS) bad_addr <= bad_addr + 1;
            if (!BUSY) we_idle <= we_idle + 1;
        end
        if (RESET) rst_cnt <= 0;
        else if (RAM_WE === 1'b1) begin
            if (rst_cnt == 0) first_addr <= RAM_A;
            rst_cnt <= rst_cnt + 1;
        end
    end

    // Screen-level reference model
    logic [7:0] exp_mem [0:2047];
    int m_row, m_col;
    bit m_inv;

    task automatic m_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) exp_mem[r*64 + c] = 8'h20;
    endtask

    task automatic m_scroll();
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++) exp_mem[r*64 + c] = exp_mem[(r+1)*64 + c];
        for (int c = 0; c < COLS; c++) exp_mem[(ROWS-1)*64 + c] = 8'h20;
    endtask

    task automatic m_apply(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_mem[m_row*64 + m_col] = {m_inv, b[6:0]};
            if (m_col == COLS - 1) begin
                m_col = 0;
                if (m_row == ROWS - 1) m_scroll();
                else m_row++;
            end else m_col++;
        end else if (b == 8'h0D) m_col = 0;
        else if (b == 8'h0A) begin
            if (m_row == ROWS - 1) m_scroll();
            else m_row++;
        end else if (b == 8'h08) begin
            if (m_col > 0) m_col--;
        end else if (b == 8'h0C) begin
            m_row = 0; m_col = 0; m_clear();
        end else if (b == 8'h0E) m_inv = 1'b1;
        else if (b == 8'h0F) m_inv = 1'b0;
    endtask

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_ready(input string tag, input int bound, output int t);
        t = 0;
        while (DATA_READY !== 1'b1 && t < bound) begin
            @(negedge CLK);
            t++;
        end
        chk(tag, 32'(DATA_READY), 32'd1);
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        wait_ready("ready_before_send", 5000, t);
        DATA = b;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        DATA = 8'h00;
        m_apply(b);
        chk("cursor_row", 32'(CURSOR_ROW), 32'(m_row));
        chk("cursor_col", 32'(CURSOR_COL), 32'(m_col));
    endtask

    task automatic cmp_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < 2048; i++) if (mem[i] !== exp_mem[i]) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int t, n, rdy_hi, w0, pick;
        logic [7:0] b;

        init_req = 1'b1; preload_req = 1'b0;
        RESET = 1'b1; DATA = 8'h00; DATA_VALID = 1'b0;
        for (int i = 0; i < 2048; i++) exp_mem[i] = 8'hFF;
        m_clear(); m_row = 0; m_col = 0; m_inv = 1'b0;

        // Reset values
        repeat (3) @(negedge CLK);
        chk("rst_we", 32'(RAM_WE), 32'd0);
        chk("rst_a", 32'(RAM_A), 32'd0);
        chk("rst_d", 32'(RAM_D), 32'h20);
        chk("rst_ready", 32'(DATA_READY), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd1);
        chk("rst_cur_row", 32'(CURSOR_ROW), 32'd0);
        chk("rst_cur_col", 32'(CURSOR_COL), 32'd0);
        init_req = 1'b0;
        RESET = 1'b0;
        wait_ready("clear_done", 5000, t);
        chk("clear_latency", 32'(t), 32'(NCELL + 1));
        chk("clear_writes", 32'(rst_cnt), 32'(NCELL));
        chk("clear_first_addr", 32'(first_addr), 32'd0);
        cmp_mem("mem_after_reset");

        // Text
        send(8'h41);
        chk("txt_we_a", 32'(RAM_WE), 32'd1);
        chk("txt_addr_a", 32'(RAM_A), 32'h000);
        chk("txt_data_a", 32'(RAM_D), 32'h41);
        chk("txt_ready_low_a", 32'(DATA_READY), 32'd0);
        send(8'h42);
        chk("txt_addr_b", 32'(RAM_A), 32'h001);
        chk("txt_data_b", 32'(RAM_D), 32'h42);
        chk("txt_ready_low_b", 32'(DATA_READY), 32'd0);
        @(negedge CLK);
        chk("txt_ready_back", 32'(DATA_READY), 32'd1);
        chk("txt_cur_col", 32'(CURSOR_COL), 32'd2);

        // Control codes
        send(8'h0D);
        chk("cr_ready_stays", 32'(DATA_READY), 32'd1);
        send(8'h0E);
        chk("inv_ready_stays", 32'(DATA_READY), 32'd1);
        send(8'h43); send(8'h0F); send(8'h44); send(8'h0D); send(8'h0A); send(8'h08);
        chk("bs_col0_row", 32'(CURSOR_ROW), 32'd1);
        chk("bs_col0_col", 32'(CURSOR_COL), 32'd0);
        wait_ready("ctl_idle", 100, t);
        chk("ctl_mem0", 32'(mem[0]), 32'hC3);
        chk("ctl_mem1", 32'(mem[1]), 32'h44);
        cmp_mem("mem_after_ctl");

        // Wrap
        send(8'h0C);
        w0 = wr_count;
        wait_ready("ff_done", 5000, t);
        chk("ff_writes", 32'(wr_count - w0), 32'(NCELL));
        for (int i = 0; i < 64; i++) send(8'h78);
        wait_ready("wrap_idle", 100, t);
        chk("wrap_last_addr", 32'(last_addr), 32'h03F);
        chk("wrap_cur_row", 32'(CURSOR_ROW), 32'd1);
        chk("wrap_cur_col", 32'(CURSOR_COL), 32'd0);
        chk("wrap_no_scroll", 32'(BUSY), 32'd0);
        cmp_mem("mem_after_wrap");

        // Scroll with preloaded row pattern
        for (int i = 0; i < 28; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h78);
        wait_ready("pre_scroll_idle", 100, t);
        preload_req = 1'b1;
        @(negedge CLK);
        preload_req = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) exp_mem[r*64 + c] = 8'(r);
        send(8'h0A);
        n = 0; rdy_hi = 0;
        while (BUSY === 1'b1 && n < 10000) begin
            if (DATA_READY !== 1'b0) rdy_hi++;
            @(negedge CLK);
            n++;
        end
        chk("scroll_busy_cycles", 32'(n), 32'(2*COLS*(ROWS-1) + COLS));
        chk("scroll_ready_low", 32'(rdy_hi), 32'd0);
        chk("scroll_cur_row", 32'(CURSOR_ROW), 32'd29);
        chk("scroll_cur_col", 32'(CURSOR_COL), 32'd5);
        chk("scroll_row0", 32'(mem[0]), 32'd1);
        chk("scroll_row29", 32'(mem[29*64 + 7]), 32'h20);
        cmp_mem("mem_after_scroll");

        // Form feed
        send(8'h0C);
        w0 = wr_count;
        wait_ready("ff2_done", 5000, t);
        chk("ff2_writes", 32'(wr_count - w0), 32'(NCELL));
        cmp_mem("mem_after_ff");

        // Reset during scroll
        for (int i = 0; i < 29; i++) send(8'h0A);
        send(8'h0A);
        repeat (100) @(negedge CLK);
        chk("midscroll_busy", 32'(BUSY), 32'd1);
        RESET = 1'b1;
        @(negedge CLK);
        chk("midrst_we", 32'(RAM_WE), 32'd0);
        chk("midrst_busy", 32'(BUSY), 32'd1);
        chk("midrst_ready", 32'(DATA_READY), 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        wait_ready("midrst_clear_done", 5000, t);
        chk("midrst_writes", 32'(rst_cnt), 32'(NCELL));
        chk("midrst_first_addr", 32'(first_addr), 32'd0);
        m_clear(); m_row = 0; m_col = 0; m_inv = 1'b0;
        chk("midrst_cur_row", 32'(CURSOR_ROW), 32'd0);
        cmp_mem("mem_after_midrst");

        // Randomized stream against the model
        for (int i = 0; i < 20; i++) send(8'h0A);
        for (int i = 0; i < 200; i++) begin
            pick = int'($urandom_range(0, 99));
            if (pick < 70)      b = 8'($urandom_range(32, 126));
            else if (pick < 78) b = 8'h0D;
            else if (pick < 84) b = 8'h0A;
            else if (pick < 90) b = 8'h08;
            else if (pick < 94) b = 8'h0E;
            else if (pick < 97) b = 8'h0F;
            else if ($urandom_range(0, 1) == 1) b = 8'($urandom_range(128, 255));
            else b = 8'h7F;
            send(b);
        end
        wait_ready("rand_idle", 5000, t);
        cmp_mem("mem_after_random");
        chk("addr_in_range", 32'(bad_addr), 32'd0);
        chk("we_only_when_busy", 32'(we_idle), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
